// File: rtl/interval_arb8.sv
// interval_arb8: four-requester round-robin arbiter driving one shared
// interval counter. The winner's 8-bit interval loads the counter as its
// inverse, the counter climbs to 8'hFF, and the winner gets a one-cycle
// done pulse. Dropping req aborts the operation. clr forces IDLE.
module interval_arb8 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [31:0] ival,
  input  logic        en,
  input  logic        clr,
  output logic [3:0]  gnt,
  output logic [3:0]  done,
  output logic        busy,
  output logic [7:0]  cnt,
  output logic        tc
);

  typedef enum logic [1:0] {IDLE, LOAD, COUNT, DONE} state_t;

  state_t      state, st_nxt;
  logic [7:0]  cnt_nxt;
  logic [3:0]  gnt_nxt, done_nxt;
  logic [1:0]  sel, sel_nxt;
  logic [1:0]  ptr, ptr_nxt;
  logic        arb_hit;
  logic [1:0]  arb_idx;
  logic [7:0]  ival_sel;

  assign ival_sel = ival[{sel, 3'b000} +: 8];
  assign busy     = (state != IDLE);
  assign tc       = (state == COUNT) && (cnt == 8'hFF);

  // Round-robin pick: search upward from ptr; descending loop lets the
  // smallest offset from ptr overwrite the others.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = ptr;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) begin
        arb_hit = 1'b1;
        arb_idx = ptr + 2'(k);
      end
    end
  end

  // Next-state and next-output logic; clr outranks everything, and
  // abort (req[sel] dropped) outranks terminal count.
  always_comb begin
    st_nxt   = state;
    cnt_nxt  = cnt;
    gnt_nxt  = gnt;
    done_nxt = 4'b0000;
    sel_nxt  = sel;
    ptr_nxt  = ptr;
    if (clr) begin
      st_nxt  = IDLE;
      cnt_nxt = 8'h00;
      gnt_nxt = 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          gnt_nxt = 4'b0000;
          if (arb_hit) begin
            sel_nxt = arb_idx;
            gnt_nxt = 4'b0001 << arb_idx;
            st_nxt  = LOAD;
          end
        end
        LOAD: begin
          if (!req[sel]) begin
            st_nxt  = IDLE;
            gnt_nxt = 4'b0000;
            ptr_nxt = sel + 2'd1;
          end else begin
            cnt_nxt = ~ival_sel;
            st_nxt  = COUNT;
          end
        end
        COUNT: begin
          if (!req[sel]) begin
            st_nxt  = IDLE;
            gnt_nxt = 4'b0000;
            ptr_nxt = sel + 2'd1;
          end else if (en) begin
            if (cnt == 8'hFF) begin
              st_nxt   = DONE;
              done_nxt = gnt;
            end else begin
              cnt_nxt = cnt + 8'd1;
            end
          end
        end
        DONE: begin
          st_nxt  = IDLE;
          gnt_nxt = 4'b0000;
          ptr_nxt = sel + 2'd1;
        end
        default: begin
          st_nxt  = IDLE;
          gnt_nxt = 4'b0000;
        end
      endcase
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 8'h00;
      gnt   <= 4'b0000;
      done  <= 4'b0000;
      sel   <= 2'd0;
      ptr   <= 2'd0;
    end else begin
      state <= st_nxt;
      cnt   <= cnt_nxt;
      gnt   <= gnt_nxt;
      done  <= done_nxt;
      sel   <= sel_nxt;
      ptr   <= ptr_nxt;
    end
  end

endmodule

// File: doc/interval_arb8.md
INTERVAL_ARB8 -- requirements
Module: interval_arb8

Interface
REQ-001 The module SHALL have parameter-free ports only; widths are fixed at 4 requesters and an 8-bit counter.
REQ-002 The ports SHALL be as follows, one per line.
  clk     in   1   single rising-edge clock
  rst_n   in   1   asynchronous active-low reset
  req     in   4   per-requester interval request, level
  ival    in   32  per-requester interval; requester i uses ival[8i+7:8i]
  en      in   1   count enable; low freezes the counter and the FSM in COUNT
  clr     in   1   synchronous abort of any operation
  gnt     out  4   one-hot grant, registered
  done    out  4   one-cycle completion pulse to the granted requester, registered
  busy    out  1   high whenever state is not IDLE
  cnt     out  8   current counter value
  tc      out  1   terminal count, equal to (cnt == 8'hFF) while in COUNT

Function
REQ-003 The FSM SHALL have the states IDLE, LOAD, COUNT and DONE, and exactly one state SHALL be active at a time.
REQ-004 In IDLE with req != 0, the arbiter SHALL select a requester round-robin, starting from index ptr and searching upward mod 4; it SHALL set gnt one-hot and move to LOAD on the next edge.
REQ-005 In IDLE with req == 0, the block SHALL stay in IDLE with gnt = 0.
REQ-006 In LOAD, the block SHALL set cnt <= 8'hFF - ival[sel] (the bitwise inverse) and move to COUNT, regardless of en.
REQ-007 In COUNT with en = 1 and cnt != 8'hFF, the block SHALL set cnt <= cnt + 1.
REQ-008 In COUNT with en = 1 and cnt == 8'hFF, the block SHALL move to DONE and leave cnt unchanged.
REQ-009 In COUNT with en = 0, cnt and the state SHALL hold.
REQ-010 With en held high, COUNT SHALL last exactly ival+1 cycles.
  - ival = 0 gives one COUNT cycle.
  - ival = 255 gives 256 COUNT cycles.
  - The counter never wraps.
REQ-011 DONE SHALL last one cycle, with done[sel] = 1 and gnt still asserted.
  - On leaving DONE: state -> IDLE, gnt -> 0, ptr <= (sel+1) mod 4.
REQ-012 The latency from req sampled in IDLE to the done pulse SHALL be ival+3 cycles with en continuously high.
REQ-013 Abort: if req[sel] = 0 in LOAD or COUNT, the block SHALL go to IDLE on the next edge.
  - gnt -> 0 and ptr <= (sel+1) mod 4.
  - No done pulse is issued.
REQ-014 If abort and terminal count coincide in the same cycle, abort SHALL win and no done SHALL be issued.
REQ-015 clr = 1 SHALL force IDLE on the next edge from any state, with gnt = 0, done = 0 and cnt = 0; ptr is unchanged; clr has priority over every other event.
REQ-016 ival SHALL be sampled only in LOAD; changes at any other time SHALL have no effect on the operation in progress.
REQ-017 A requester holding req high through DONE SHALL re-enter arbitration in IDLE at lowest priority because of the ptr advance.
REQ-018 gnt SHALL never have more than one bit set, and done SHALL be zero outside DONE.

Reset
REQ-019 When rst_n = 0, the block SHALL immediately, independent of clk, set:
  - state = IDLE, cnt = 8'h00, gnt = 4'b0000, done = 4'b0000, busy = 0, tc = 0, ptr = 0.
REQ-020 Deassertion of rst_n SHALL take effect at the next rising clk edge; the first arbitration after reset SHALL favour requester 0.
REQ-021 Reset asserted mid-operation SHALL discard that operation with no done pulse.

Verification
REQ-022 The bench SHALL cover each of the following directed scenarios.
  - Basic: req=4'b0100, ival[23:16]=3, en=1 -> gnt=4'b0100 from cycle 1, cnt FC,FD,FE,FF in cycles 2-5, done=4'b0100 in cycle 6 only, busy=0 in cycle 7.
  - Round-robin: req=4'b1111 held with all ival=0 -> grants in order 0,1,2,3,0, each operation 4 cycles (IDLE, LOAD, COUNT, DONE).
  - Enable stall: ival=2, en=0 for 5 cycles mid-COUNT -> cnt holds; done arrives 5 cycles later than the 5-cycle baseline.
  - Abort: req[sel] dropped in the cycle where cnt=FF -> no done, IDLE next cycle, ptr advanced.
  - Clear and reset: clr=1 in COUNT -> IDLE with cnt=00 next edge; rst_n pulsed low mid-COUNT -> all outputs zero before the next edge.
  - Boundary: ival=255 -> exactly 256 COUNT cycles, done at cycle 258, and cnt never wraps to 00.
